// File: rtl/accel_result_collector.sv
// accel_result_collector
//   Receiving end of the accelerator output stream. Every valid result is
//   captured into a first-word-fall-through FIFO together with its
//   end-of-frame tag, completed frames are counted, and dropped words raise
//   a sticky overflow flag. The host/DMA side drains the FIFO through a
//   valid/ready read port with zero read latency.
//
//   Optional feature macro: COLLECTOR_RELU_EN
//     defined   -> negative results are clamped to zero before storage
//     undefined -> results are stored bit-exact
module accel_result_collector #(
   parameter int N     = 16,
   parameter int Q     = 12,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          global_rst,
   input  logic          clr,
   input  logic [N-1:0]  data_in,
   input  logic          valid_in,
   input  logic          end_in,
   input  logic          rd_ready,
   output logic [N-1:0]  rd_data,
   output logic          rd_valid,
   output logic          rd_last,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          frame_done,
   output logic [7:0]    frame_cnt
);

   // Occupancy value that means every slot holds a word.
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   // The pointers wrap naturally only when DEPTH fills the pointer range,
   // and the fractional point must sit inside the word.
   if (((1 << AW) != DEPTH) || (Q < 0) || (Q >= N)) begin : g_param_check
      $error("accel_result_collector: DEPTH must equal 2**AW and Q must be in 0..N-1");
   end

   // Storage: each entry is {last, data}.
   logic [N:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic          overflow_q;
   logic          frame_done_q;
   logic [7:0]    frame_cnt_q;

   logic          fifo_full;
   logic          fifo_nonempty;
   logic          pop_req;
   logic          push_en;
   logic          pop_en;
   logic          drop_word;
   logic [N-1:0]  store_data;

`ifdef COLLECTOR_RELU_EN
   // ReLU: a negative two's-complement result is replaced by zero; the
   // end-of-frame tag travels alongside untouched.
   always_comb begin
      store_data = data_in;
      if (data_in[N-1]) begin
         store_data = '0;
      end
   end
`else
   // Results are stored exactly as the accelerator produced them.
   always_comb begin
      store_data = data_in;
   end
`endif

   // Handshake decode. A pop in the same cycle frees a slot, so a full FIFO
   // still accepts a push when the consumer is reading. clr overrides every
   // other event in its cycle.
   always_comb begin
      fifo_full     = (count_q == FullCount);
      fifo_nonempty = (count_q != '0);
      pop_req       = fifo_nonempty && rd_ready;
      pop_en        = pop_req && !clr;
      push_en       = valid_in && (!fifo_full || pop_req) && !clr;
      drop_word     = valid_in && fifo_full && !pop_req && !clr;
   end

   // Storage array; cleared on reset so the read port shows zero before any
   // word has ever been written. clr leaves contents alone because an empty
   // FIFO's head word is stale by definition.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_en) begin
         mem[wr_ptr] <= {end_in, store_data};
      end
   end

   // Write pointer advances on every accepted push and wraps mod DEPTH.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         wr_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
      end else if (push_en) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Read pointer advances on every accepted pop and wraps mod DEPTH.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         rd_ptr <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
      end else if (pop_en) begin
         rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy is kept in its own counter instead of subtracting pointers,
   // which cannot tell full from empty when they are equal.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else begin
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overflow: set when a valid word had nowhere to go.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         overflow_q <= 1'b0;
      end else if (clr) begin
         overflow_q <= 1'b0;
      end else if (drop_word) begin
         overflow_q <= 1'b1;
      end
   end

   // Frame tracking: end_in closes a frame whether or not its word was
   // valid or stored, so a dropped last word still completes the frame.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else if (clr) begin
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         frame_done_q <= end_in;
         if (end_in) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   // Read port: head word falls through combinationally from the array.
   always_comb begin
      {rd_last, rd_data} = mem[rd_ptr];
      rd_valid           = fifo_nonempty;
      count              = count_q;
      overflow           = overflow_q;
      frame_done         = frame_done_q;
      frame_cnt          = frame_cnt_q;
   end

endmodule

// File: tb/tb_accel_result_collector.sv
// Self-checking bench for accel_result_collector.
//   A queue-based reference model predicts what the FIFO must hold; words
//   are pushed onto the scoreboard when driven and compared when popped.
//   The basic push/read frame is also checked against a hand-written table.
module tb_accel_result_collector;

   localparam int N     = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          global_rst;
   logic          clr;
   logic [N-1:0]  data_in;
   logic          valid_in;
   logic          end_in;
   logic          rd_ready;
   logic [N-1:0]  rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic [AW:0]   count;
   logic          overflow;
   logic          frame_done;
   logic [7:0]    frame_cnt;

   int            compared   = 0;
   int            mismatched = 0;

   logic [N:0]    sb_q [$];
   logic          mdl_overflow;
   logic          mdl_frame_done;
   logic [7:0]    mdl_frame_cnt;

   typedef struct {
      logic          valid;
      logic          end_f;
      logic          rd_rdy;
      logic [N-1:0]  data;
      logic [AW:0]   exp_count;
      logic          exp_fd;
      logic [7:0]    exp_fc;
      logic [N-1:0]  exp_head;
      logic          exp_last;
   } vec_t;

   vec_t vecs [7];

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   accel_result_collector #(
      .N     (N),
      .Q     (12),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .clr        (clr),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .end_in     (end_in),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_last    (rd_last),
      .count      (count),
      .overflow   (overflow),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   // Expected stored value of a driven word.
   function automatic logic [N-1:0] reluModel(input logic [N-1:0] d);
`ifdef COLLECTOR_RELU_EN
      return d[N-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare all status outputs and the head word against the model.
   task automatic checkModel();
      logic [N:0] head;
      checkOutput("count",      32'(count),      32'(sb_q.size()));
      checkOutput("rd_valid",   32'(rd_valid),   32'(sb_q.size() != 0));
      checkOutput("overflow",   32'(overflow),   32'(mdl_overflow));
      checkOutput("frame_done", 32'(frame_done), 32'(mdl_frame_done));
      checkOutput("frame_cnt",  32'(frame_cnt),  32'(mdl_frame_cnt));
      if (sb_q.size() != 0) begin
         head = sb_q[0];
         checkOutput("head_data", 32'(rd_data), 32'(head[N-1:0]));
         checkOutput("head_last", 32'(rd_last), 32'(head[N]));
      end
   endtask

   // One clock cycle: called at a falling edge, drives inputs, updates the
   // model for the coming rising edge, then checks at the next falling edge.
   task automatic applyStimulus(input logic c, input logic v, input logic e,
                                input logic r, input logic [N-1:0] d);
      logic       pop_now;
      logic       full_now;
      logic [N:0] head;
      pop_now  = (sb_q.size() != 0) && r;
      full_now = (sb_q.size() == DEPTH);
      if (pop_now && !c) begin
         head = sb_q[0];
         checkOutput("pop_data", 32'(rd_data), 32'(head[N-1:0]));
         checkOutput("pop_last", 32'(rd_last), 32'(head[N]));
      end
      clr      = c;
      valid_in = v;
      end_in   = e;
      rd_ready = r;
      data_in  = d;
      if (c) begin
         sb_q.delete();
         mdl_overflow   = 1'b0;
         mdl_frame_done = 1'b0;
         mdl_frame_cnt  = 8'd0;
      end else begin
         if (pop_now) begin
            void'(sb_q.pop_front());
         end
         if (v) begin
            if (!full_now || pop_now) begin
               sb_q.push_back({e, reluModel(d)});
            end else begin
               mdl_overflow = 1'b1;
            end
         end
         mdl_frame_done = e;
         if (e) begin
            mdl_frame_cnt = mdl_frame_cnt + 8'd1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      checkModel();
   endtask

   // Assert reset between edges and confirm every output drops at once.
   task automatic resetMidStream();
      clr      = 1'b0;
      valid_in = 1'b0;
      end_in   = 1'b0;
      rd_ready = 1'b0;
      data_in  = '0;
      #2;
      global_rst = 1'b1;
      #1;
      checkOutput("rst_rd_data",    32'(rd_data),    32'd0);
      checkOutput("rst_rd_valid",   32'(rd_valid),   32'd0);
      checkOutput("rst_rd_last",    32'(rd_last),    32'd0);
      checkOutput("rst_count",      32'(count),      32'd0);
      checkOutput("rst_overflow",   32'(overflow),   32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_frame_cnt",  32'(frame_cnt),  32'd0);
      sb_q.delete();
      mdl_overflow   = 1'b0;
      mdl_frame_done = 1'b0;
      mdl_frame_cnt  = 8'd0;
      @(negedge clk);
      global_rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1000, 5'd1, 1'b0, 8'd0, 16'h1000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h2000, 5'd2, 1'b0, 8'd0, 16'h1000, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h3000, 5'd3, 1'b1, 8'd1, 16'h1000, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'd3, 1'b0, 8'd1, 16'h1000, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd2, 1'b0, 8'd1, 16'h2000, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd1, 1'b0, 8'd1, 16'h3000, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b0, 8'd1, 16'h0000, 1'b0};

      global_rst     = 1'b1;
      clr            = 1'b0;
      valid_in       = 1'b0;
      end_in         = 1'b0;
      rd_ready       = 1'b0;
      data_in        = '0;
      mdl_overflow   = 1'b0;
      mdl_frame_done = 1'b0;
      mdl_frame_cnt  = 8'd0;

      // Power-on reset state.
      #12;
      checkOutput("por_rd_data",  32'(rd_data),  32'd0);
      checkOutput("por_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("por_count",    32'(count),    32'd0);
      checkOutput("por_frame",    32'(frame_cnt), 32'd0);
      @(negedge clk);
      global_rst = 1'b0;

      // Three-word frame, then read back in order.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, vecs[i].valid, vecs[i].end_f, vecs[i].rd_rdy, vecs[i].data);
         checkOutput($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         checkOutput($sformatf("tbl%0d_fdone", i), 32'(frame_done), 32'(vecs[i].exp_fd));
         checkOutput($sformatf("tbl%0d_fcnt", i), 32'(frame_cnt), 32'(vecs[i].exp_fc));
         if (vecs[i].exp_count != 0) begin
            checkOutput($sformatf("tbl%0d_head", i), 32'(rd_data), 32'(vecs[i].exp_head));
            checkOutput($sformatf("tbl%0d_last", i), 32'(rd_last), 32'(vecs[i].exp_last));
         end
      end

      // end_in without valid_in closes a frame but tags nothing.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h7777);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0123);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0456);

      // Mid-stream reset empties everything immediately.
      resetMidStream();
      checkModel();

      // Fill to the brim, then a 17th word with end_in is dropped.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
      checkOutput("ovf_set",   32'(overflow),  32'd1);
      checkOutput("ovf_count", 32'(count),     32'd16);
      checkOutput("ovf_frame", 32'(frame_cnt), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      end
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO with simultaneous push and pop keeps its occupancy.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0200 + i));
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'(16'h0300 + i));
         checkOutput("full_pp_count", 32'(count),    32'd16);
         checkOutput("full_pp_ovf",   32'(overflow), 32'd0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      end

      // clr together with a push wins.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, (i == 2), 1'b0, 16'(16'h0400 + i));
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0999);
      checkOutput("clr_count",    32'(count),     32'd0);
      checkOutput("clr_rd_valid", 32'(rd_valid),  32'd0);
      checkOutput("clr_overflow", 32'(overflow),  32'd0);
      checkOutput("clr_frame",    32'(frame_cnt), 32'd0);
      checkOutput("clr_fdone",    32'(frame_done), 32'd0);

      // Negative then positive half: clamped only when ReLU is built in.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'hF800);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0800);
`ifdef COLLECTOR_RELU_EN
      checkOutput("relu_neg", 32'(rd_data), 32'h0000);
`else
      checkOutput("relu_neg", 32'(rd_data), 32'hF800);
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      checkOutput("relu_pos", 32'(rd_data), 32'h0800);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

      // Frame counter wraps from 255 back to 0.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      end
      checkOutput("fcnt_wrap", 32'(frame_cnt), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
